fifo_rd_stream_adapter: RTL
===========================

// Module: fifo_rd_stream_adapter
// PURPOSE
//  Read-side consumer of small_async_fifo, in the rclk domain. Drives rinc, captures the
//  registered FIFO rdata (1-cycle read latency) into a 3-entry output buffer and presents
//  it as a valid/ready stream to the DMA datapath. Sustains 1 word/clk with m_tready high;
//  no combinational path from m_tready to rinc.
// PARAMETERS
//  DSIZE   8   data width; must equal the FIFO DSIZE
//  CNT_W   16  width of m_word_cnt (FIFO_RD_CNT_EN only)
// PORTS
//  rclk        in   1      clock (single clock, FIFO read clock)
//  rrst_n      in   1      synchronous active-low reset
//  flush       in   1      synchronous drop of all buffered and in-flight words
//  rempty      in   1      FIFO empty (registered, from FIFO)
//  rdata       in   DSIZE  FIFO read data, valid the cycle after rinc
//  rinc        out  1      FIFO read strobe
//  m_tdata     out  DSIZE  stream data (head of buffer)
//  m_tvalid    out  1      stream valid
//  m_tready    in   1      stream ready
//  m_word_cnt  out  CNT_W  accepted-beat counter (FIFO_RD_CNT_EN only)
// BEHAVIOUR
//  - Reset (rrst_n=0 at rclk edge): rinc=0, m_tvalid=0, m_tdata=0, buf_cnt=0, rd_pend=0,
//    m_word_cnt=0. All state is synchronous; no async reset term.
//  - Occupancy occ = buf_cnt (0..3) + rd_pend (0/1). Read issue rule, registered terms only:
//    rinc = ~rempty & ~flush & (occ < 3). rinc is never asserted while rempty=1, because the
//    FIFO memory updates rdata on rinc even when empty.
//  - rd_pend <= rinc. In the cycle where rd_pend=1, rdata is written into the buffer tail.
//  - Pop: m_tvalid & m_tready removes the head. Push and pop in the same cycle leave buf_cnt
//    unchanged; the order is preserved.
//  - Buffer states EMPTY(0) / ONE / TWO / FULL(3) with m_tvalid = (buf_cnt != 0).
//    Transitions: push only +1, pop only -1, push and pop 0. A push in FULL cannot occur
//    because of the occ rule; the implementation asserts this.
//  - m_tdata is the registered head entry. It is stable while m_tvalid & ~m_tready
//    (AXI-S hold rule: once m_tvalid is high it stays high until it is accepted).
//  - Latency: FIFO non-empty with buffer EMPTY -> rinc at cycle t -> capture at t+1 ->
//    m_tvalid=1 at t+2.
//  - Throughput: with m_tready held high, steady state is occ=2 and one beat per clk.
//  - Flush (synchronous, has priority over push and pop): buf_cnt <= 0, m_tvalid <= 0.
//    A word returning on rdata in the flush cycle or the next cycle (rd_pend) is discarded,
//    not pushed. rinc=0 during flush. m_word_cnt is not cleared.
//  - Reset during operation: all words in flight are lost. The FIFO pointers are reset by
//    the same rrst_n.
//  - Internal indices wrap modulo 3. Read and write pointers are 2-bit values wrapping
//    2 -> 0. buf_cnt saturates logically at 3 by construction.
// CONFIGURATION
//  FIFO_RD_CNT_EN defined:
//    - m_word_cnt port present.
//    - Increments by 1 on every m_tvalid & m_tready beat and wraps from 2^CNT_W-1 to 0.
//    - Reset to 0 by rrst_n only.
//  FIFO_RD_CNT_EN undefined:
//    - Port and counter are absent. Stream behaviour is identical.
// TESTING
//  1. Reset; rempty=0 with 5 words 0x11..0x15; m_tready=1 -> rinc high 5 cycles, beats
//     0x11..0x15 on 5 consecutive clks starting 2 clks after the first rinc.
//  2. FIFO holds 8 words; m_tready=0 -> exactly 3 rinc pulses, buffer FULL, m_tdata=first
//     word held stable; raise m_tready -> all 8 words delivered in order, no gap after restart.
//  3. Random m_tready (50%) and random rempty gaps, 1000 words -> data sequence matches the
//     scoreboard; rinc never high while rempty=1; no beat lost or duplicated.
//  4. Flush asserted in the cycle after a rinc with buf_cnt=2 -> next cycle m_tvalid=0; the
//     pending word is not delivered; the next FIFO word is the next beat.
//  5. rrst_n=0 for 1 clk mid-burst -> next cycle: rinc=0, m_tvalid=0, m_tdata=0.
//  6. FIFO_RD_CNT_EN, CNT_W=4: 18 accepted beats -> m_word_cnt=2 (wrapped); flush leaves it
//     unchanged.

Source files
------------

// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter: small_async_fifo read side to a valid/ready stream through a 3-entry buffer.
// Define FIFO_RD_CNT_EN to add the m_word_cnt accepted-beat counter.
module fifo_rd_stream_adapter #(
  parameter int DSIZE = 8
`ifdef FIFO_RD_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             flush,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic [DSIZE-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready
`ifdef FIFO_RD_CNT_EN
  , output logic [CNT_W-1:0] m_word_cnt
`endif
);
  logic [DSIZE-1:0] mem [3];
  logic [1:0] buf_cnt, rd_ptr, wr_ptr;
  logic [2:0] occ;
  logic rd_pend, push, pop;
  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction
  // in-flight read counts toward occupancy so a returning word always has a free slot
  assign occ = {1'b0, buf_cnt} + {2'b0, rd_pend};
  assign rinc = rrst_n & ~rempty & ~flush & (occ < 3'd3);
  assign m_tvalid = buf_cnt != 2'd0;
  assign m_tdata = mem[rd_ptr];
  assign pop = m_tvalid & m_tready;
  assign push = rd_pend & ~flush;
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      buf_cnt <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      rd_pend <= 1'b0;
      for (int i = 0; i < 3; i++) mem[i] <= '0;
    end else begin
      rd_pend <= rinc;
      if (flush) begin
        buf_cnt <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) mem[wr_ptr] <= rdata;
        wr_ptr <= push ? nxt(wr_ptr) : wr_ptr;
        rd_ptr <= pop ? nxt(rd_ptr) : rd_ptr;
        buf_cnt <= (push & ~pop) ? buf_cnt + 2'd1 : (pop & ~push) ? buf_cnt - 2'd1 : buf_cnt;
      end
    end
  end
`ifdef FIFO_RD_CNT_EN
  always_ff @(posedge rclk) begin
    if (!rrst_n) m_word_cnt <= '0;
    else if (pop) m_word_cnt <= m_word_cnt + 1'b1;
  end
`endif
  a_no_push_full: assert property (@(posedge rclk) disable iff (!rrst_n) !(rd_pend && buf_cnt == 2'd3));
endmodule
